// File: rtl/axil_pkg.sv
// axil_pkg -- shared definitions for the AXI-Lite slave blocks.
//   RESP_OKAY / RESP_SLVERR : AXI response encodings
//   rd_state_t              : read-channel FSM states
//   wr_state_t              : write-channel FSM states
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_COMMIT,
        W_RESP
    } wr_state_t;

endpackage

// File: rtl/axil_sram_bank_mem.sv
// axil_sram_bank_mem -- DEPTH x DATA_W storage array.
//   clk   : clock
//   we    : write enable (byte lanes selected by wstrb)
//   widx  : write word index
//   wdata : write data
//   wstrb : byte write strobes
//   ridx  : read word index
//   rdata : combinational read data (pre-write value on a same-cycle write)
// Contents are never reset. Kept separate so it can be replaced by a macro.
module axil_sram_bank_mem
    import axil_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IDX_W-1:0]    widx,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [IDX_W-1:0]    ridx,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < DATA_W / 8; i++) begin
                if (wstrb[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/axil_sram_bank.sv
// axil_sram_bank -- parametrised AXI-Lite slave SRAM with independent read
// and write channels, byte strobes, configurable read latency and an address
// window; out-of-window accesses complete with SLVERR.
//   clk, rst                         : clock, synchronous active-high reset
//   araddr/arvalid/arready           : read address channel
//   rdata/rresp/rvalid/rready        : read data channel
//   awaddr/awvalid/awready           : write address channel
//   wdata/wstrb/wvalid/wready        : write data channel
//   bresp/bvalid/bready              : write response channel
// Optional build macro AXIL_SRAM_BANK_RAND_LAT_EN: a 16-bit LFSR replaces
// RD_LAT with a 1-8 cycle read wait and adds a 0-3 cycle write-commit stall.
module axil_sram_bank
    import axil_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000,
    parameter int unsigned       RD_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam int unsigned       STRB_W    = DATA_W / 8;
    localparam int unsigned       OFF_W     = $clog2(STRB_W);
    localparam int unsigned       IDX_W     = $clog2(DEPTH);
    localparam int unsigned       CNT_W     = $clog2(RD_LAT + 8);
    localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(DEPTH * STRB_W);

    rd_state_t r_state, r_next;
    wr_state_t w_state, w_next;

    logic [ADDR_W-1:0] ar_addr_q, ar_off;
    logic [ADDR_W-1:0] aw_addr_q, aw_off;
    logic              ar_hit, aw_hit;
    logic [IDX_W-1:0]  ar_idx, aw_idx;
    logic [CNT_W-1:0]  r_cnt, rd_load;
    logic [DATA_W-1:0] wdata_q, mem_rdata;
    logic [STRB_W-1:0] wstrb_q;
    logic              aw_done, w_done;
    logic              aw_hs, w_hs, both_in;
    logic              commit_now, mem_we;

`ifdef AXIL_SRAM_BANK_RAND_LAT_EN
    logic [15:0] lfsr;
    logic [1:0]  w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign rd_load    = CNT_W'(lfsr[2:0]);
    assign commit_now = (w_stall == 2'd0);
`else
    assign rd_load    = CNT_W'(RD_LAT - 1);
    assign commit_now = 1'b1;
`endif

    // Offsets wrap below BASE_ADDR, so one unsigned compare covers both ends.
    assign ar_off = ar_addr_q - BASE_ADDR;
    assign aw_off = aw_addr_q - BASE_ADDR;
    assign ar_hit = (ar_off < WIN_BYTES);
    assign aw_hit = (aw_off < WIN_BYTES);
    assign ar_idx = ar_off[OFF_W +: IDX_W];
    assign aw_idx = aw_off[OFF_W +: IDX_W];

    // ---------------- read channel ----------------
    assign arready = (r_state == R_IDLE);
    assign rvalid  = (r_state == R_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: if (arvalid)         r_next = R_WAIT;
            R_WAIT: if (r_cnt == '0)     r_next = R_RESP;
            R_RESP: if (rready)          r_next = R_IDLE;
            default:                     r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar_addr_q <= '0;
            r_cnt     <= '0;
            rdata     <= '0;
            rresp     <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid) begin
                        ar_addr_q <= araddr;
                        r_cnt     <= rd_load;
                    end
                end
                R_WAIT: begin
                    if (r_cnt == '0) begin
                        rdata <= ar_hit ? mem_rdata : '0;
                        rresp <= ar_hit ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- write channel ----------------
    assign awready = (w_state == W_IDLE) && !aw_done;
    assign wready  = (w_state == W_IDLE) && !w_done;
    assign bvalid  = (w_state == W_RESP);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    // A channel counts as latched either from an earlier cycle or from this one.
    assign both_in = (aw_done || aw_hs) && (w_done || w_hs);
    assign mem_we  = (w_state == W_COMMIT) && commit_now && aw_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:   if (both_in)    w_next = W_COMMIT;
            W_COMMIT: if (commit_now) w_next = W_RESP;
            W_RESP:   if (bready)     w_next = W_IDLE;
            default:                  w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            bresp     <= RESP_OKAY;
`ifdef AXIL_SRAM_BANK_RAND_LAT_EN
            w_stall   <= 2'd0;
`endif
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_addr_q <= awaddr;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                        w_done  <= 1'b1;
                    end
`ifdef AXIL_SRAM_BANK_RAND_LAT_EN
                    if (both_in) begin
                        w_stall <= lfsr[4:3];
                    end
`endif
                end
                W_COMMIT: begin
                    if (commit_now) begin
                        bresp   <= aw_hit ? RESP_OKAY : RESP_SLVERR;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
`ifdef AXIL_SRAM_BANK_RAND_LAT_EN
                    else begin
                        w_stall <= w_stall - 2'd1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    axil_sram_bank_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .widx  (aw_idx),
        .wdata (wdata_q),
        .wstrb (wstrb_q),
        .ridx  (ar_idx),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_axil_sram_bank.sv
// tb_axil_sram_bank -- self-checking bench for axil_sram_bank (default build).
// A word-array reference model tracks memory contents from the write rules;
// directed scenarios cover the listed cases, then a randomized mix follows.
module tb_axil_sram_bank;

    localparam int unsigned TB_DEPTH  = 64;
    localparam int unsigned TB_RD_LAT = 2;
    localparam logic [31:0] TB_BASE   = 32'h8000_0000;
    localparam logic [31:0] TB_WIN    = TB_DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr, awaddr, wdata;
    logic        arvalid, rready, awvalid, wvalid, bready;
    logic [3:0]  wstrb;
    logic        arready, rvalid, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mdl [TB_DEPTH];

    axil_sram_bank #(
        .DATA_W    (32),
        .ADDR_W    (32),
        .DEPTH     (TB_DEPTH),
        .BASE_ADDR (TB_BASE),
        .RD_LAT    (TB_RD_LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: merge enabled byte lanes of an in-window write.
    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        logic [31:0] off;
        int unsigned idx;
        off = addr - TB_BASE;
        if (off < TB_WIN) begin
            idx = off / 4;
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - TB_BASE;
        return (off < TB_WIN) ? mdl[off / 4] : 32'h0;
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - TB_BASE;
        return (off < TB_WIN) ? 2'b00 : 2'b10;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input bit b_early, input int b_hold,
                            output logic [1:0] resp, output int pulses, output bit tmo);
        int c;
        bit aw_p, w_p, aw_t, w_t;
        aw_p = 1; w_p = 1; tmo = 0; pulses = 0; resp = 2'bxx; c = 0;
        awaddr = addr; wdata = data; wstrb = strb; bready = b_early;
        while ((aw_p || w_p) && c < 50) begin
            awvalid = aw_p && (c >= aw_dly);
            wvalid  = w_p && (c >= w_dly);
            aw_t = awvalid && awready;
            w_t  = wvalid && wready;
            tick();
            if (aw_t) aw_p = 0;
            if (w_t)  w_p = 0;
            c++;
        end
        awvalid = 0; wvalid = 0;
        if (aw_p || w_p) begin tmo = 1; bready = 0; return; end
        c = 0;
        while (!bvalid && c < 50) begin tick(); c++; end
        if (!bvalid) begin tmo = 1; bready = 0; return; end
        resp = bresp;
        pulses = 1;
        if (!b_early) begin
            repeat (b_hold) tick();
            bready = 1;
        end
        tick();
        bready = 0;
        repeat (4) begin
            if (bvalid) pulses++;
            tick();
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input bit r_early, input int r_hold,
                           output logic [31:0] data, output logic [1:0] resp, output int lat,
                           output bit stable, output bit ack_ok, output bit tmo);
        int c;
        tmo = 0; stable = 1; ack_ok = 0; data = '0; resp = '0; lat = 0; c = 0;
        araddr = addr; arvalid = 1; rready = r_early;
        while (!arready && c < 50) begin tick(); c++; end
        if (!arready) begin tmo = 1; arvalid = 0; rready = 0; return; end
        tick();
        arvalid = 0;
        lat = 1;
        while (!rvalid && lat < 60) begin tick(); lat++; end
        if (!rvalid) begin tmo = 1; rready = 0; return; end
        data = rdata; resp = rresp;
        if (arready !== 1'b0) stable = 0;
        if (!r_early) begin
            repeat (r_hold) begin
                tick();
                if (rvalid !== 1'b1 || rdata !== data || rresp !== resp || arready !== 1'b0) stable = 0;
            end
            rready = 1;
        end
        tick();
        rready = 0;
        ack_ok = (rvalid === 1'b0) && (arready === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1;
        araddr = '0; arvalid = 0; rready = 0;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        repeat (3) tick();
        n_cmp++;
        if ({arready, awready, wready} !== 3'b111) begin
            n_bad++; $display("FAIL reset_readys: got %b want 111", {arready, awready, wready});
        end
        n_cmp++;
        if ({rvalid, bvalid} !== 2'b00) begin
            n_bad++; $display("FAIL reset_valids: got %b want 00", {rvalid, bvalid});
        end
        n_cmp++;
        if (rdata !== 32'h0 || rresp !== 2'b00 || bresp !== 2'b00) begin
            n_bad++; $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b want 0/00/00", rdata, rresp, bresp);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_fill();
        logic [1:0] resp; int pulses; bit tmo; logic [31:0] d;
        for (int i = 0; i < TB_DEPTH; i++) begin
            d = $urandom;
            do_write(TB_BASE + 4 * i, d, 4'hF, 0, 0, 1'b1, 0, resp, pulses, tmo);
            mdl[i] = d;
            n_cmp++;
            if (tmo || resp !== 2'b00) begin
                n_bad++; $display("FAIL fill_bresp[%0d]: got %b tmo=%0d want 00", i, resp, tmo);
            end
        end
    endtask

    task automatic test_basic();
        logic [1:0] resp; int pulses, lat; bit tmo, st, ack; logic [31:0] d;
        do_write(TB_BASE, 32'hDEADBEEF, 4'hF, 0, 0, 1'b0, 1, resp, pulses, tmo);
        model_write(TB_BASE, 32'hDEADBEEF, 4'hF);
        n_cmp++;
        if (tmo || resp !== 2'b00 || pulses != 1) begin
            n_bad++; $display("FAIL basic_write: bresp=%b pulses=%0d tmo=%0d want 00/1/0", resp, pulses, tmo);
        end
        do_read(TB_BASE, 1'b0, 0, d, resp, lat, st, ack, tmo);
        n_cmp++;
        if (tmo || d !== 32'hDEADBEEF || resp !== 2'b00) begin
            n_bad++; $display("FAIL basic_read: rdata=%h rresp=%b want deadbeef/00", d, resp);
        end
`ifndef AXIL_SRAM_BANK_RAND_LAT_EN
        n_cmp++;
        if (lat != TB_RD_LAT + 1) begin
            n_bad++; $display("FAIL basic_latency: got %0d cycles want %0d", lat, TB_RD_LAT + 1);
        end
`endif
        n_cmp++;
        if (!ack) begin
            n_bad++; $display("FAIL basic_r_ack: rvalid=%b arready=%b want 0/1", rvalid, arready);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp; int pulses, lat; bit tmo, st, ack; logic [31:0] d, a;
        a = TB_BASE + 4 * 5;
        do_write(a, 32'h11223344, 4'hF, 0, 0, 1'b1, 0, resp, pulses, tmo);
        model_write(a, 32'h11223344, 4'hF);
        do_write(a, 32'hAABBCCDD, 4'b0101, 0, 0, 1'b1, 0, resp, pulses, tmo);
        model_write(a, 32'hAABBCCDD, 4'b0101);
        do_read(a, 1'b1, 0, d, resp, lat, st, ack, tmo);
        n_cmp++;
        if (tmo || d !== 32'h11BB33DD || resp !== 2'b00) begin
            n_bad++; $display("FAIL strobe_0101: rdata=%h rresp=%b want 11bb33dd/00", d, resp);
        end
        do_write(a, 32'hFFFFFFFF, 4'b0000, 0, 0, 1'b1, 0, resp, pulses, tmo);
        n_cmp++;
        if (tmo || resp !== 2'b00) begin
            n_bad++; $display("FAIL strobe_zero_bresp: got %b want 00", resp);
        end
        do_read(a + 3, 1'b1, 0, d, resp, lat, st, ack, tmo);
        n_cmp++;
        if (tmo || d !== 32'h11BB33DD) begin
            n_bad++; $display("FAIL strobe_zero_data: rdata=%h want 11bb33dd", d);
        end
    endtask

    task automatic test_miss();
        logic [1:0] resp; int pulses, lat; bit tmo, st, ack; logic [31:0] d;
        do_read(TB_BASE - 4, 1'b0, 2, d, resp, lat, st, ack, tmo);
        n_cmp++;
        if (tmo || d !== 32'h0 || resp !== 2'b10) begin
            n_bad++; $display("FAIL miss_read: rdata=%h rresp=%b want 0/10", d, resp);
        end
        do_write(TB_BASE + TB_WIN, 32'h5A5A5A5A, 4'hF, 0, 0, 1'b0, 0, resp, pulses, tmo);
        n_cmp++;
        if (tmo || resp !== 2'b10) begin
            n_bad++; $display("FAIL miss_write: bresp=%b want 10", resp);
        end
        do_read(TB_BASE + TB_WIN - 4, 1'b1, 0, d, resp, lat, st, ack, tmo);
        n_cmp++;
        if (tmo || d !== mdl[TB_DEPTH-1] || resp !== 2'b00) begin
            n_bad++; $display("FAIL miss_last_word: rdata=%h rresp=%b want %h/00", d, resp, mdl[TB_DEPTH-1]);
        end
        do_read(TB_BASE, 1'b1, 0, d, resp, lat, st, ack, tmo);
        n_cmp++;
        if (tmo || d !== mdl[0]) begin
            n_bad++; $display("FAIL miss_word0_kept: rdata=%h want %h", d, mdl[0]);
        end
    endtask

    task automatic test_order();
        logic [1:0] resp; int pulses, lat; bit tmo, st, ack; logic [31:0] d, a, v;
        int aw_d [3] = '{3, 0, 0};
        int w_d  [3] = '{0, 0, 2};
        for (int k = 0; k < 3; k++) begin
            a = TB_BASE + 4 * (7 + k);
            v = $urandom;
            do_write(a, v, 4'hF, aw_d[k], w_d[k], 1'b0, k, resp, pulses, tmo);
            model_write(a, v, 4'hF);
            n_cmp++;
            if (tmo || resp !== 2'b00 || pulses != 1) begin
                n_bad++; $display("FAIL order_%0d_bpulse: bresp=%b pulses=%0d want 00/1", k, resp, pulses);
            end
            do_read(a, 1'b1, 0, d, resp, lat, st, ack, tmo);
            n_cmp++;
            if (tmo || d !== v) begin
                n_bad++; $display("FAIL order_%0d_data: rdata=%h want %h", k, d, v);
            end
        end
    endtask

    task automatic test_rready_stall();
        logic [1:0] resp; int lat; bit tmo, st, ack; logic [31:0] d, a;
        a = TB_BASE + 4 * 12;
        do_read(a, 1'b0, 5, d, resp, lat, st, ack, tmo);
        n_cmp++;
        if (tmo || d !== mdl[12] || !st) begin
            n_bad++; $display("FAIL rstall_stable: rdata=%h stable=%0d want %h/1", d, st, mdl[12]);
        end
        n_cmp++;
        if (!ack) begin
            n_bad++; $display("FAIL rstall_ack: rvalid=%b arready=%b want 0/1", rvalid, arready);
        end
    endtask

    task automatic test_collision();
        logic [1:0] resp; int lat; bit tmo, st, ack; logic [31:0] d, a, old_v, new_v;
        a = TB_BASE + 4 * 10;
        old_v = mdl[10];
        new_v = ~old_v;
        araddr = a; arvalid = 1;
        tick();
        arvalid = 0;
        repeat (TB_RD_LAT - 2) tick();
        awaddr = a; wdata = new_v; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        tick();
        n_cmp++;
        if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== old_v) begin
            n_bad++; $display("FAIL collision_pre: rvalid=%b bvalid=%b rdata=%h want 1/1/%h", rvalid, bvalid, rdata, old_v);
        end
        rready = 1; bready = 1;
        tick();
        rready = 0; bready = 0;
        model_write(a, new_v, 4'hF);
        do_read(a, 1'b1, 0, d, resp, lat, st, ack, tmo);
        n_cmp++;
        if (tmo || d !== new_v) begin
            n_bad++; $display("FAIL collision_post: rdata=%h want %h", d, new_v);
        end
    endtask

    task automatic test_reset_midflight();
        logic [1:0] resp; int lat; bit tmo, st, ack; logic [31:0] d, a, v;
        a = TB_BASE + 4 * 20;
        v = $urandom;
        awaddr = a; wdata = v; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        tick();
        awvalid = 0; wvalid = 0;
        tick();
        model_write(a, v, 4'hF);
        araddr = TB_BASE + 4 * 21; arvalid = 1;
        tick();
        arvalid = 0;
        rst = 1;
        tick();
        rst = 0;
        n_cmp++;
        if ({rvalid, bvalid, arready, awready, wready} !== 5'b00111) begin
            n_bad++; $display("FAIL midreset_state: rv/bv/ar/aw/w=%b want 00111", {rvalid, bvalid, arready, awready, wready});
        end
        repeat (3) begin
            tick();
            n_cmp++;
            if (rvalid !== 1'b0 || bvalid !== 1'b0) begin
                n_bad++; $display("FAIL midreset_no_resp: rvalid=%b bvalid=%b want 0/0", rvalid, bvalid);
            end
        end
        do_read(a, 1'b1, 0, d, resp, lat, st, ack, tmo);
        n_cmp++;
        if (tmo || d !== v) begin
            n_bad++; $display("FAIL midreset_mem_a: rdata=%h want %h", d, v);
        end
        do_read(TB_BASE + 4 * 21, 1'b1, 0, d, resp, lat, st, ack, tmo);
        n_cmp++;
        if (tmo || d !== mdl[21]) begin
            n_bad++; $display("FAIL midreset_mem_b: rdata=%h want %h", d, mdl[21]);
        end
    endtask

    task automatic test_random();
        logic [1:0] resp; int pulses, lat; bit tmo, st, ack; logic [31:0] d, a, v;
        logic [3:0] s;
        int op;
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 9);
            if (op < 2) begin
                if ($urandom_range(0, 1) == 1)
                    a = TB_BASE + TB_WIN + 4 * $urandom_range(0, 15);
                else
                    a = TB_BASE - 4 * $urandom_range(1, 16);
            end else begin
                a = TB_BASE + 4 * $urandom_range(0, TB_DEPTH - 1) + $urandom_range(0, 3);
            end
            if (op % 2 == 0) begin
                v = $urandom;
                s = 4'($urandom_range(0, 15));
                do_write(a, v, s, $urandom_range(0, 3), $urandom_range(0, 3),
                         1'($urandom_range(0, 1)), $urandom_range(0, 3), resp, pulses, tmo);
                model_write(a, v, s);
                n_cmp++;
                if (tmo || resp !== model_resp(a) || pulses != 1) begin
                    n_bad++; $display("FAIL rand_write[%0d] a=%h: bresp=%b pulses=%0d want %b/1", n, a, resp, pulses, model_resp(a));
                end
            end else begin
                do_read(a, 1'($urandom_range(0, 1)), $urandom_range(0, 3), d, resp, lat, st, ack, tmo);
                n_cmp++;
                if (tmo || d !== model_read(a) || resp !== model_resp(a) || !st || !ack) begin
                    n_bad++; $display("FAIL rand_read[%0d] a=%h: rdata=%h rresp=%b st=%0d ack=%0d want %h/%b/1/1",
                                      n, a, d, resp, st, ack, model_read(a), model_resp(a));
                end
`ifndef AXIL_SRAM_BANK_RAND_LAT_EN
                n_cmp++;
                if (lat != TB_RD_LAT + 1) begin
                    n_bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, TB_RD_LAT + 1);
                end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_strobe();
        test_miss();
        test_order();
        test_rready_stall();
        test_collision();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
